ccr_unit: RTL and testbench
===========================

CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: alu_en  in  1  execute-stage ALU result valid this cycle.
REQ-004 SHALL have port: func  in  4  ALU function code of the executing instruction (same encoding as the ALU).
REQ-005 SHALL have port: c_in, n_in, z_in  in  1 each  ALU carry, negative and zero outputs.
REQ-006 SHALL have port: stall  in  1  freeze all state; no flag, shadow or FSM update.
REQ-007 SHALL have port: jmp_valid  in  1  conditional or unconditional jump evaluating this cycle.
REQ-008 SHALL have port: jmp_type  in  2  00 JZ, 01 JN, 10 JC, 11 JMP.
REQ-009 SHALL have port: int_save  in  1  interrupt entry: copy CCR to shadow.
REQ-010 SHALL have port: rti_restore  in  1  return from interrupt: copy shadow to CCR.
REQ-011 SHALL have port: ccr  out  3  registered flags {C,N,Z}.
REQ-012 SHALL have port: jmp_taken  out  1  combinational jump decision.
REQ-013 SHALL have port: nest_err  out  1  one-cycle registered pulse on illegal save/restore.

Function
REQ-014 SHALL, on rising clk with alu_en=1 and stall=0, update flags per func: 0 inc, 1 dec, 2 add, 3 sub, 8 shl, 9 shr -> C,N,Z from inputs; 5 not, 6 or, 7 and -> N,Z only, C held; 4 mov -> none; 10 setc -> C=1; 11 clc -> C=0; 12-15 -> none.
REQ-015 SHALL hold all flags when alu_en=0.
REQ-016 SHALL drive jmp_taken = jmp_valid AND (JZ: Z; JN: N; JC: C; JMP: 1), evaluated on the registered ccr, zero latency.
REQ-017 SHALL, when a JZ/JN/JC is taken and stall=0, clear the tested flag at the next edge; JMP clears nothing.
REQ-018 SHALL, when an ALU update and a taken-jump clear hit the same flag in the same cycle, apply the clear (clear wins); other flags take the ALU update.
REQ-019 SHALL implement a 2-state FSM: IDLE (shadow empty) and SAVED (shadow valid).
REQ-020 SHALL, on int_save in IDLE, load shadow with the next-state CCR (after REQ-014/017 effects that cycle) and enter SAVED.
REQ-021 SHALL, on rti_restore in SAVED, load CCR from shadow, overriding any ALU update or jump clear that cycle, and return to IDLE.
REQ-022 SHALL, on int_save in SAVED or rti_restore in IDLE, leave shadow, FSM and CCR-restore untouched, pulse nest_err for one cycle, and still apply normal ALU/jump updates.
REQ-023 SHALL, with int_save and rti_restore both high, treat the cycle as rti_restore only.
REQ-024 SHALL, while stall=1, hold ccr, shadow, FSM state and drive nest_err=0; jmp_taken stays combinational.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, set ccr=000, shadow=000, FSM=IDLE, nest_err=0, overriding all other inputs including stall.
REQ-026 SHALL, on reset asserted mid-interrupt (SAVED), discard shadow contents.

Structure
REQ-027 SHALL take ALU function codes, jmp_type encodings and flag bit indices (C=2, N=1, Z=0) from shared package ccr_pkg, also used by the ALU.
REQ-028 SHALL place the jump decision in one combinational sub-module, jump_cond_eval.

Verification
REQ-029 SHALL check: reset, then alu_en=1 func=3 c/n/z=0/1/0 -> ccr=010 next cycle; jmp JN -> jmp_taken=1, ccr=000 after edge.
REQ-030 SHALL check: ccr=001, func=7 with c/n/z=1/0/0 -> ccr=000 (C held 0); func=10 -> ccr=100; func=11 -> ccr=000; func=4 -> unchanged.
REQ-031 SHALL check: ccr=000, alu_en func=2 z_in=1 with JZ valid same cycle -> jmp_taken=0 (registered Z=0), ccr=001; next cycle JZ -> taken, ccr=000.
REQ-032 SHALL check: ccr=101, int_save -> SAVED; func=2 sets ccr=010; rti_restore with func=2 active -> ccr=101, IDLE.
REQ-033 SHALL check: rti_restore in IDLE -> nest_err=1 one cycle, ccr per ALU; int_save twice -> second pulses nest_err, shadow keeps first value.
REQ-034 SHALL check: stall=1 with alu_en and taken JC -> ccr unchanged, jmp_taken=1; rst during SAVED -> ccr=000, later rti_restore pulses nest_err.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared condition-code definitions: ALU function codes, jump encodings and flag bit positions.
// The ALU imports this package too, so func encodings cannot drift between the two blocks.
package ccr_pkg;

  localparam int unsigned FUNC_W = 4;
  localparam int unsigned JMP_W  = 2;
  localparam int unsigned CCR_W  = 3;

  // Flag bit positions inside the {C,N,Z} register
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam logic [FUNC_W-1:0] FUNC_INC  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_DEC  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_MOV  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_NOT  = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_SHL  = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_SHR  = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_SETC = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_CLC  = 4'd11;

  localparam logic [JMP_W-1:0] JMP_JZ  = 2'b00;
  localparam logic [JMP_W-1:0] JMP_JN  = 2'b01;
  localparam logic [JMP_W-1:0] JMP_JC  = 2'b10;
  localparam logic [JMP_W-1:0] JMP_JMP = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SAVED = 1'b1
  } ccr_state_e;

  // One-hot mask of the flag a conditional jump tests; zero for JMP
  function automatic logic [CCR_W-1:0] flag_mask(input logic [JMP_W-1:0] jtype);
    logic [CCR_W-1:0] m;
    m = '0;
    case (jtype)
      JMP_JZ:  m[FLAG_Z] = 1'b1;
      JMP_JN:  m[FLAG_N] = 1'b1;
      JMP_JC:  m[FLAG_C] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccr_unit_jump_cond_eval.sv
// Combinational jump decision from the registered flags, plus the mask of the flag
// a taken conditional jump consumes.
module jump_cond_eval
  import ccr_pkg::*;
(
  input  logic             jmp_valid,
  input  logic [JMP_W-1:0] jmp_type,
  input  logic [CCR_W-1:0] ccr,
  output logic             taken_c,
  output logic [CCR_W-1:0] clr_mask_c
);

  logic cond;

  always_comb begin
    cond       = 1'b0;
    clr_mask_c = '0;
    case (jmp_type)
      JMP_JZ:  cond = ccr[FLAG_Z];
      JMP_JN:  cond = ccr[FLAG_N];
      JMP_JC:  cond = ccr[FLAG_C];
      default: cond = 1'b1;
    endcase
    taken_c = jmp_valid & cond;
    if (taken_c) begin
      clr_mask_c = flag_mask(jmp_type);
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register with jump-consumed flags and a single-level interrupt shadow.
// Restore from the shadow overrides ALU and jump effects in the same cycle.
module ccr_unit
  import ccr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_en,
  input  logic [FUNC_W-1:0] func,
  input  logic              c_in,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              stall,
  input  logic              jmp_valid,
  input  logic [JMP_W-1:0]  jmp_type,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [CCR_W-1:0]  ccr,
  output logic              jmp_taken,
  output logic              nest_err
);

  ccr_state_e       state_q, state_d;
  logic [CCR_W-1:0] shadow_q, shadow_d;
  logic [CCR_W-1:0] ccr_d;
  logic             nest_err_d;
  logic [CCR_W-1:0] clr_mask_c;
  logic [CCR_W-1:0] alu_ccr_c;
  logic [CCR_W-1:0] upd_ccr_c;

  jump_cond_eval u_jump_cond_eval (
    .jmp_valid  (jmp_valid),
    .jmp_type   (jmp_type),
    .ccr        (ccr),
    .taken_c    (jmp_taken),
    .clr_mask_c (clr_mask_c)
  );

  // ALU flag update, then taken-jump clear on top (clear wins)
  always_comb begin
    alu_ccr_c = ccr;
    if (alu_en) begin
      case (func)
        FUNC_INC, FUNC_DEC, FUNC_ADD, FUNC_SUB, FUNC_SHL, FUNC_SHR: begin
          alu_ccr_c[FLAG_C] = c_in;
          alu_ccr_c[FLAG_N] = n_in;
          alu_ccr_c[FLAG_Z] = z_in;
        end
        FUNC_NOT, FUNC_OR, FUNC_AND: begin
          alu_ccr_c[FLAG_N] = n_in;
          alu_ccr_c[FLAG_Z] = z_in;
        end
        FUNC_SETC: alu_ccr_c[FLAG_C] = 1'b1;
        FUNC_CLC:  alu_ccr_c[FLAG_C] = 1'b0;
        FUNC_MOV:  alu_ccr_c = ccr;
        default:   alu_ccr_c = ccr;
      endcase
    end
    upd_ccr_c = alu_ccr_c & ~clr_mask_c;
  end

  // Shadow FSM next-state; rti_restore takes priority over int_save
  always_comb begin
    state_d    = state_q;
    ccr_d      = upd_ccr_c;
    shadow_d   = shadow_q;
    nest_err_d = 1'b0;
    if (stall) begin
      ccr_d = ccr;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rti_restore) begin
            nest_err_d = 1'b1;
          end else if (int_save) begin
            shadow_d = upd_ccr_c;
            state_d  = ST_SAVED;
          end
        end
        ST_SAVED: begin
          if (rti_restore) begin
            ccr_d   = shadow_q;
            state_d = ST_IDLE;
          end else if (int_save) begin
            nest_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ccr      <= '0;
      shadow_q <= '0;
      nest_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      ccr      <= ccr_d;
      shadow_q <= shadow_d;
      nest_err <= nest_err_d;
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed scenarios plus randomized traffic
// compared against a flag-level reference model.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst, alu_en, c_in, n_in, z_in, stall, jmp_valid, int_save, rti_restore;
  logic [3:0] func;
  logic [1:0] jmp_type;
  logic [2:0] ccr;
  logic       jmp_taken, nest_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: flags as {C,N,Z}
  logic [2:0] m_ccr, m_shadow;
  logic       m_saved, m_nest;

  ccr_unit dut (
    .clk(clk), .rst(rst), .alu_en(alu_en), .func(func),
    .c_in(c_in), .n_in(n_in), .z_in(z_in), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_type(jmp_type),
    .int_save(int_save), .rti_restore(rti_restore),
    .ccr(ccr), .jmp_taken(jmp_taken), .nest_err(nest_err)
  );

  always #5 clk = ~clk;

  function automatic logic model_taken();
    case (jmp_type)
      2'b00:   return jmp_valid & m_ccr[0];
      2'b01:   return jmp_valid & m_ccr[1];
      2'b10:   return jmp_valid & m_ccr[2];
      default: return jmp_valid;
    endcase
  endfunction

  // Advance the model by one rising edge using the currently driven inputs
  task automatic model_clock();
    logic [2:0] nxt;
    if (rst) begin
      m_ccr = 3'b000; m_shadow = 3'b000; m_saved = 1'b0; m_nest = 1'b0;
    end else if (stall) begin
      m_nest = 1'b0;
    end else begin
      nxt = m_ccr;
      if (alu_en) begin
        if (func inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9}) nxt = {c_in, n_in, z_in};
        else if (func inside {4'd5, 4'd6, 4'd7}) nxt = {m_ccr[2], n_in, z_in};
        else if (func == 4'd10) nxt[2] = 1'b1;
        else if (func == 4'd11) nxt[2] = 1'b0;
      end
      if (model_taken() && jmp_type != 2'b11) nxt[jmp_type] = 1'b0;
      m_nest = 1'b0;
      if (rti_restore) begin
        if (m_saved) begin nxt = m_shadow; m_saved = 1'b0; end
        else m_nest = 1'b1;
      end else if (int_save) begin
        if (!m_saved) begin m_shadow = nxt; m_saved = 1'b1; end
        else m_nest = 1'b1;
      end
      m_ccr = nxt;
    end
  endtask

  task automatic drive(input logic a_en, input logic [3:0] f, input logic [2:0] cnz,
                       input logic jv, input logic [1:0] jt, input logic sv,
                       input logic rr, input logic st, input logic r);
    alu_en = a_en; func = f; {c_in, n_in, z_in} = cnz;
    jmp_valid = jv; jmp_type = jt; int_save = sv; rti_restore = rr; stall = st; rst = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd2, 3'b111, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    vectors++;
    if (ccr !== 3'b000) begin miscompares++; $display("FAIL reset_ccr got=%b want=000", ccr); end
    vectors++;
    if (nest_err !== 1'b0) begin miscompares++; $display("FAIL reset_nest got=%b want=0", nest_err); end
  endtask

  task automatic test_sub_jn();
    drive(1'b1, 4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ccr !== 3'b010) begin miscompares++; $display("FAIL sub_flags got=%b want=010", ccr); end
    drive(1'b0, 4'd0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (jmp_taken !== 1'b1) begin miscompares++; $display("FAIL jn_taken got=%b want=1", jmp_taken); end
    tick();
    vectors++;
    if (ccr !== 3'b000) begin miscompares++; $display("FAIL jn_clear got=%b want=000", ccr); end
  endtask

  task automatic test_logic_flags();
    logic [3:0] fl [5]  = '{4'd2, 4'd7, 4'd10, 4'd11, 4'd0};
    logic [2:0] in [5]  = '{3'b001, 3'b100, 3'b000, 3'b111, 3'b010};
    logic [2:0] ex [5]  = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b010};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, fl[i], in[i], 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ccr !== ex[i]) begin
        miscompares++; $display("FAIL logic_flags[%0d] func=%0d got=%b want=%b", i, fl[i], ccr, ex[i]);
      end
    end
    drive(1'b1, 4'd4, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ccr !== 3'b010) begin miscompares++; $display("FAIL mov_hold got=%b want=010", ccr); end
  endtask

  task automatic test_jump_clear();
    drive(1'b1, 4'd11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (jmp_taken !== 1'b0) begin miscompares++; $display("FAIL jz_stale got=%b want=0", jmp_taken); end
    tick();
    vectors++;
    if (ccr !== 3'b001) begin miscompares++; $display("FAIL jz_setz got=%b want=001", ccr); end
    drive(1'b0, 4'd0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (jmp_taken !== 1'b1) begin miscompares++; $display("FAIL jz_taken got=%b want=1", jmp_taken); end
    tick();
    vectors++;
    if (ccr !== 3'b000) begin miscompares++; $display("FAIL jz_clear got=%b want=000", ccr); end
  endtask

  task automatic test_save_restore();
    drive(1'b1, 4'd2, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ccr !== 3'b010) begin miscompares++; $display("FAIL isr_update got=%b want=010", ccr); end
    drive(1'b1, 4'd2, 3'b111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ccr !== 3'b101) begin miscompares++; $display("FAIL rti_restore got=%b want=101", ccr); end
    vectors++;
    if (nest_err !== 1'b0) begin miscompares++; $display("FAIL rti_nest got=%b want=0", nest_err); end
  endtask

  task automatic test_nest_err();
    drive(1'b1, 4'd0, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (nest_err !== 1'b1 || ccr !== 3'b001) begin
      miscompares++; $display("FAIL rti_idle nest=%b ccr=%b want nest=1 ccr=001", nest_err, ccr);
    end
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (nest_err !== 1'b0) begin miscompares++; $display("FAIL nest_pulse got=%b want=0", nest_err); end
    drive(1'b1, 4'd2, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (nest_err !== 1'b1 || ccr !== 3'b010) begin
      miscompares++; $display("FAIL double_save nest=%b ccr=%b want nest=1 ccr=010", nest_err, ccr);
    end
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ccr !== 3'b001 || nest_err !== 1'b0) begin
      miscompares++; $display("FAIL shadow_kept ccr=%b nest=%b want ccr=001 nest=0", ccr, nest_err);
    end
  endtask

  task automatic test_stall_reset();
    drive(1'b1, 4'd10, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (jmp_taken !== 1'b1) begin miscompares++; $display("FAIL stall_jc_taken got=%b want=1", jmp_taken); end
    tick();
    vectors++;
    if (ccr !== 3'b101) begin miscompares++; $display("FAIL stall_hold got=%b want=101", ccr); end
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    vectors++;
    if (nest_err !== 1'b0) begin miscompares++; $display("FAIL stall_nest got=%b want=0", nest_err); end
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    vectors++;
    if (ccr !== 3'b000) begin miscompares++; $display("FAIL rst_saved got=%b want=000", ccr); end
    drive(1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (nest_err !== 1'b1 || ccr !== 3'b000) begin
      miscompares++; $display("FAIL rst_discard nest=%b ccr=%b want nest=1 ccr=000", nest_err, ccr);
    end
  endtask

  task automatic test_random();
    logic et;
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 3'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 49) == 0));
      et = model_taken();
      vectors++;
      if (jmp_taken !== et) begin
        miscompares++; $display("FAIL rand_taken[%0d] got=%b want=%b", i, jmp_taken, et);
      end
      tick();
      vectors++;
      if (ccr !== m_ccr || nest_err !== m_nest) begin
        miscompares++;
        $display("FAIL rand_state[%0d] ccr=%b nest=%b want ccr=%b nest=%b", i, ccr, nest_err, m_ccr, m_nest);
      end
    end
  endtask

  initial begin
    m_ccr = 3'bxxx; m_shadow = 3'bxxx; m_saved = 1'b0; m_nest = 1'b0;
    test_reset();
    test_sub_jn();
    test_logic_flags();
    test_jump_clear();
    test_save_restore();
    test_nest_err();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
